// File: rtl/mult16_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mult16_share_ctrl
// Brief    : Round-robin scheduler sharing one 16x16 unsigned multiplier
//            between two valid/ready requesters; returns the 32-bit product
//            on a valid/ready response channel tagged with the requester id.
// Revision : 1.0 - initial release
// ============================================================================

// Combinational 16x16 unsigned array multiplier (single shared instance).
module array_mult16 (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [31:0] product_o
);
    assign product_o = {16'b0, a_i} * {16'b0, b_i};
endmodule

module mult16_share_ctrl #(
    parameter int SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_product,
    output logic        busy,
    output logic [15:0] op_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0] c_settle_cnt = 4'(SETTLE);

    state_t      state_q, state_d;
    logic        ptr_q, ptr_d;
    logic [15:0] op_a_q, op_a_d;
    logic [15:0] op_b_q, op_b_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        rsp_id_q, rsp_id_d;
    logic [31:0] rsp_product_q, rsp_product_d;
    logic [15:0] op_count_q, op_count_d;
    logic        busy_q;

    logic        w_grant;
    logic        w_any_valid;
    logic [31:0] w_product;

    // Operand registers feed the one shared multiplier for the whole CALC window.
    array_mult16 u_mult (
        .a_i       (op_a_q),
        .b_i       (op_b_q),
        .product_o (w_product)
    );

    // Pointer only matters when both request; otherwise the lone requester wins.
    assign w_any_valid = req0_valid | req1_valid;
    assign w_grant     = (req0_valid && req1_valid) ? ptr_q : req1_valid;

    // Next-state, handshake and datapath-load decisions.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        cnt_d         = cnt_q;
        rsp_id_d      = rsp_id_q;
        rsp_product_d = rsp_product_q;
        op_count_d    = op_count_q;
        req0_ready    = 1'b0;
        req1_ready    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_any_valid) begin
                    req0_ready = ~w_grant;
                    req1_ready = w_grant;
                    op_a_d     = w_grant ? req1_a : req0_a;
                    op_b_d     = w_grant ? req1_b : req0_b;
                    rsp_id_d   = w_grant;
                    cnt_d      = c_settle_cnt;
                    ptr_d      = ~w_grant;
                    state_d    = S_CALC;
                end
            end
            S_CALC: begin
                // cnt_q == 1 marks the SETTLE-th cycle of operand hold.
                if (cnt_q == 4'd1) begin
                    rsp_product_d = w_product;
                    state_d       = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    op_count_d = op_count_q + 16'd1;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            ptr_q         <= 1'b0;
            op_a_q        <= 16'd0;
            op_b_q        <= 16'd0;
            cnt_q         <= 4'd0;
            rsp_id_q      <= 1'b0;
            rsp_product_q <= 32'd0;
            op_count_q    <= 16'd0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            cnt_q         <= cnt_d;
            rsp_id_q      <= rsp_id_d;
            rsp_product_q <= rsp_product_d;
            op_count_q    <= op_count_d;
            busy_q        <= (state_d != S_IDLE);
        end
    end

    assign rsp_valid   = (state_q == S_RESP);
    assign rsp_id      = rsp_id_q;
    assign rsp_product = rsp_product_q;
    assign busy        = busy_q;
    assign op_count    = op_count_q;

endmodule
`default_nettype wire

// File: tb/tb_mult16_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult16_share_ctrl
// Brief    : Directed self-checking bench for mult16_share_ctrl (SETTLE=2),
//            plus SETTLE=1 and SETTLE=15 instances for latency checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult16_share_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_ready, req1_ready;
    logic        rsp_valid, rsp_ready, rsp_id, busy;
    logic [31:0] rsp_product;
    logic [15:0] op_count;

    logic        lat_valid;
    logic [15:0] lat_a, lat_b;
    logic        s1_r0rdy, s1_r1rdy, s1_vld, s1_id, s1_busy;
    logic [31:0] s1_prod;
    logic [15:0] s1_cnt;
    logic        s15_r0rdy, s15_r1rdy, s15_vld, s15_id, s15_busy;
    logic [31:0] s15_prod;
    logic [15:0] s15_cnt;

    int          n_asserts;
    int          n_fail;
    logic [15:0] exp_cnt;

    mult16_share_ctrl #(.SETTLE(2)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_product(rsp_product), .busy(busy), .op_count(op_count)
    );

    mult16_share_ctrl #(.SETTLE(1)) u_s1 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(lat_valid), .req0_ready(s1_r0rdy), .req0_a(lat_a), .req0_b(lat_b),
        .req1_valid(1'b0), .req1_ready(s1_r1rdy), .req1_a(16'd0), .req1_b(16'd0),
        .rsp_valid(s1_vld), .rsp_ready(1'b1), .rsp_id(s1_id),
        .rsp_product(s1_prod), .busy(s1_busy), .op_count(s1_cnt)
    );

    mult16_share_ctrl #(.SETTLE(15)) u_s15 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(lat_valid), .req0_ready(s15_r0rdy), .req0_a(lat_a), .req0_b(lat_b),
        .req1_valid(1'b0), .req1_ready(s15_r1rdy), .req1_a(16'd0), .req1_b(16'd0),
        .rsp_valid(s15_vld), .rsp_ready(1'b1), .rsp_id(s15_id),
        .rsp_product(s15_prod), .busy(s15_busy), .op_count(s15_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One complete operation on the SETTLE=2 instance with rsp_ready held high.
    task automatic run_op(input logic id, input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] exp_p, input string tag);
        int n;
        @(negedge clk);
        rsp_ready = 1'b1;
        if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
        else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
        #1;
        chk({tag, "_ready"}, {31'd0, (id ? req1_ready : req0_ready)}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        n = 1;
        while (!rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'd3);
        chk({tag, "_product"}, rsp_product, exp_p);
        chk({tag, "_id"}, {31'd0, rsp_id}, {31'd0, id});
        @(posedge clk);
        @(negedge clk);
        exp_cnt = exp_cnt + 16'd1;
        chk({tag, "_opcount"}, {16'd0, op_count}, {16'd0, exp_cnt});
        chk({tag, "_valid_drop"}, {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        int          cyc, nresp, overlap, bad, n1, n15;
        logic        ids   [4];
        logic [31:0] prods [4];
        int          times [4];

        n_asserts = 0;
        n_fail    = 0;
        exp_cnt   = 16'd0;
        rst_n      = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = 16'd0; req0_b = 16'd0; req1_a = 16'd0; req1_b = 16'd0;
        rsp_ready  = 1'b0;
        lat_valid  = 1'b0; lat_a = 16'd0; lat_b = 16'd0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outputs", {req0_ready, req1_ready, rsp_valid, rsp_id, busy, 27'd0}, 32'd0);
        chk("rst_product", rsp_product, 32'd0);
        chk("rst_opcount", {16'd0, op_count}, 32'd0);
        rst_n = 1'b1;

        // Single op and width extremes (last grant by req1 leaves pointer at 0)
        run_op(1'b0, 16'd3,     16'd5,     32'h0000_000F, "op_3x5");
        run_op(1'b1, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, "op_max");
        run_op(1'b0, 16'h8000, 16'h0002, 32'h0001_0000, "op_msb");
        run_op(1'b1, 16'h0000, 16'h1234, 32'h0000_0000, "op_zero");

        // Fairness: both valid continuously
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 16'd7;     req0_b = 16'd9;
        req1_valid = 1'b1; req1_a = 16'h0100; req1_b = 16'h0100;
        rsp_ready  = 1'b1;
        nresp = 0; overlap = 0; cyc = 0;
        while (nresp < 4 && cyc < 60) begin
            #1;
            if (req0_ready && req1_ready) overlap++;
            if (rsp_valid) begin
                ids[nresp]   = rsp_id;
                prods[nresp] = rsp_product;
                times[nresp] = cyc;
                nresp++;
                if (nresp == 4) begin
                    req0_valid = 1'b0;
                    req1_valid = 1'b0;
                end
            end
            @(negedge clk);
            cyc++;
        end
        chk("fair_nresp", 32'(nresp), 32'd4);
        chk("fair_overlap", 32'(overlap), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("fair_id", {31'd0, ids[i]}, {31'd0, i[0]});
            chk("fair_product", prods[i], i[0] ? 32'h0001_0000 : 32'h0000_003F);
        end
        for (int i = 1; i < 4; i++) chk("fair_spacing", 32'(times[i] - times[i-1]), 32'd4);
        exp_cnt = exp_cnt + 16'd4;
        chk("fair_opcount", {16'd0, op_count}, {16'd0, exp_cnt});

        // Backpressure with req1 waiting
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 16'h1111; req0_b = 16'h0003;
        rsp_ready  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 16'h0002; req1_b = 16'h0004;
        cyc = 0;
        while (!rsp_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("bp_reached_resp", {31'd0, rsp_valid}, 32'd1);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (rsp_product !== 32'h0000_3333 || rsp_id !== 1'b0 ||
                req1_ready !== 1'b0 || rsp_valid !== 1'b1) bad++;
            @(negedge clk);
        end
        chk("bp_hold", 32'(bad), 32'd0);
        chk("bp_product", rsp_product, 32'h0000_3333);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        exp_cnt = exp_cnt + 16'd1;
        #1;
        chk("bp_req1_accept", {31'd0, req1_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req1_valid = 1'b0;
        cyc = 0;
        while (!rsp_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("bp_req1_product", rsp_product, 32'h0000_0008);
        chk("bp_req1_id", {31'd0, rsp_id}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        exp_cnt = exp_cnt + 16'd1;
        chk("bp_opcount", {16'd0, op_count}, {16'd0, exp_cnt});

        // Reset mid-CALC after a req0 grant (pointer would otherwise favour req1)
        req0_valid = 1'b1; req0_a = 16'd5; req0_b = 16'd5;
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        chk("midrst_busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs", {req0_ready, req1_ready, rsp_valid, rsp_id, busy, 27'd0}, 32'd0);
        chk("midrst_opcount", {16'd0, op_count}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        exp_cnt = 16'd0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid !== 1'b0 || busy !== 1'b0) bad++;
            @(negedge clk);
        end
        chk("midrst_no_rsp", 32'(bad), 32'd0);
        req0_valid = 1'b1; req0_a = 16'd2; req0_b = 16'd3;
        req1_valid = 1'b1; req1_a = 16'd4; req1_b = 16'd4;
        #1;
        chk("midrst_ptr_grant", {30'd0, req1_ready, req0_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        cyc = 0;
        while (!rsp_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("midrst_product", rsp_product, 32'h0000_0006);
        chk("midrst_id", {31'd0, rsp_id}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        exp_cnt = exp_cnt + 16'd1;
        chk("midrst_opcount_after", {16'd0, op_count}, {16'd0, exp_cnt});

        // Counter wrap: preload the count just below rollover
        force u_dut.op_count_q = 16'hFFFF;
        #1;
        release u_dut.op_count_q;
        #1;
        chk("wrap_preload", {16'd0, op_count}, 32'h0000_FFFF);
        exp_cnt = 16'hFFFF;
        run_op(1'b0, 16'h0010, 16'h0010, 32'h0000_0100, "wrap");
        chk("wrap_zero", {16'd0, op_count}, 32'd0);

        // SETTLE=1 and SETTLE=15 latencies to rsp_valid
        @(negedge clk);
        lat_valid = 1'b1; lat_a = 16'hABCD; lat_b = 16'h0010;
        @(posedge clk);
        @(negedge clk);
        lat_valid = 1'b0;
        n1 = 0; n15 = 0;
        for (int c = 1; c <= 25; c++) begin
            if (s1_vld && n1 == 0) n1 = c;
            if (s15_vld && n15 == 0) n15 = c;
            if (s1_vld)  chk("s1_product", s1_prod, 32'h000A_BCD0);
            if (s15_vld) chk("s15_product", s15_prod, 32'h000A_BCD0);
            @(negedge clk);
        end
        chk("s1_latency", 32'(n1), 32'd2);
        chk("s15_latency", 32'(n15), 32'd16);
        chk("s1_opcount", {16'd0, s1_cnt}, 32'd1);
        chk("s15_opcount", {16'd0, s15_cnt}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mult16_share_ctrl.md
# mult16_share_ctrl

Two-requester scheduler that time-shares one instance of the team's 16x16 combinational array multiplier (`array_mult16`). It arbitrates round-robin between two valid/ready requesters and registers the selected operands. It holds them stable for a programmable number of settle cycles, captures the 32-bit product, and returns it on a valid/ready response channel tagged with the requester ID.

## Interface

Parameters:

- `SETTLE`, default 2: number of cycles operands are held at the multiplier inputs before the product is captured; legal range 1..15.

Ports (one clock; reset is asynchronous and active-low):

- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `req0_valid` input 1: requester 0 has an operation.
- `req0_ready` output 1: requester 0 operands accepted this cycle.
- `req0_a` input 16: requester 0 multiplicand.
- `req0_b` input 16: requester 0 multiplier.
- `req1_valid` input 1: requester 1 has an operation.
- `req1_ready` output 1: requester 1 operands accepted this cycle.
- `req1_a` input 16: requester 1 multiplicand.
- `req1_b` input 16: requester 1 multiplier.
- `rsp_valid` output 1: response available.
- `rsp_ready` input 1: consumer takes response.
- `rsp_id` output 1: requester that issued the response.
- `rsp_product` output 32: unsigned product a*b.
- `busy` output 1: high in CALC and RESP.
- `op_count` output 16: number of completed responses, wraps 0xFFFF -> 0x0000.

## Operation

- Three-state FSM:
  - IDLE: if any `reqN_valid`, grant one requester, capture its a/b into operand registers, record `rsp_id`, load the settle counter, go to CALC. Otherwise stay.
  - CALC: operand registers drive the multiplier. The counter counts down; on the SETTLE-th CALC cycle the multiplier output is registered into `rsp_product`, and the FSM goes to RESP.
  - RESP: `rsp_valid`=1. On `rsp_ready`=1, increment `op_count` and go to IDLE.
- Grant rules:
  - `reqN_ready` is combinational: high only in IDLE, for the granted requester, and only when that requester's valid is high.
  - At most one ready is high per cycle.
  - Handshake = valid & ready on the same edge.
- Round-robin: 1-bit priority pointer, reset 0.
  - Both valid: grant the pointer value.
  - One valid: grant that one.
  - After any grant, the pointer becomes the non-granted index.
- Requesters must hold valid, a and b stable until ready. Deasserting valid before ready is allowed; no grant occurs and there is no side effect.
- While `rsp_valid`=1 and `rsp_ready`=0: `rsp_product` and `rsp_id` are held unchanged, and no new request is accepted.
- Arithmetic: unsigned 16x16 -> 32. No truncation or saturation.
- Reset mid-operation (any state):
  - All registers clear immediately and the pointer returns to 0.
  - The in-flight result is discarded; no response is produced and `op_count` does not increment.

## Timing

- Reset values: `req0_ready`=0, `req1_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_product`=0, `busy`=0, `op_count`=0, FSM=IDLE, pointer=0.
- Accept in cycle 0 (IDLE):
  - CALC occupies cycles 1..SETTLE.
  - Product is captured on the rising edge ending cycle SETTLE.
  - `rsp_valid` is first high in cycle SETTLE+1.
- With `rsp_ready` held high, the next accept can occur in cycle SETTLE+2. Peak throughput is one operation per SETTLE+2 cycles.
- `busy` is registered: high from cycle 1 through the last RESP cycle.
- `op_count` updates on the edge of the response handshake.
- `rsp_ready` is a don't-care outside RESP.
- A request arriving during CALC or RESP waits; it is never dropped.

## Test plan

- Single op, SETTLE=2: reset, then `req0` a=3, b=5 accepted in cycle 0 -> `rsp_valid` in cycle 3, `rsp_product`=0x0000000F, `rsp_id`=0, `op_count`=1.
- Width extremes:
  - a=0xFFFF, b=0xFFFF -> 0xFFFE0001.
  - a=0x8000, b=0x0002 -> 0x00010000.
  - a=0, b=0x1234 -> 0.
- Fairness: both requesters valid continuously, `rsp_ready`=1 -> grant order 0,1,0,1. Each `rsp_id` matches, responses are spaced SETTLE+2 cycles apart, and neither ready is ever high in the same cycle as the other.
- Backpressure: `rsp_ready`=0 for 5 cycles in RESP with `req1` valid -> product and id held constant, `req1_ready` stays 0. `req1` is accepted in the cycle after the response handshake.
- Reset mid-CALC: assert `rst_n`=0 in cycle 1 of an op -> all outputs 0 asynchronously, no response after release. The next simultaneous requests grant requester 0 first.
- Counter wrap: preload via 65535 responses (or a force) -> the 65536th response sets `op_count` to 0x0000; SETTLE=1 and SETTLE=15 latencies are checked as 2 and 16 cycles to `rsp_valid`.
